rewire_out_fifo: RTL and testbench

Downstream consumer of the 16-bit `__out0` word stream produced by the ReWire pipeline `top_level`. It classifies each word by its 2-bit tag, discards idle and illegal words, counts the accepted words per class, and buffers them in a DEPTH-entry FIFO. The FIFO drains through a valid/ready handshake to the host side. It also reports overflow and protocol-error status.

---
 rtl/rewire_out_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_rewire_out_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rewire_out_fifo.sv
// ---------------------------------------------------------------------------
// rewire_out_fifo
//
// Consumer of the 16-bit word stream coming out of the ReWire `top_level`
// pipeline. Each incoming word is classified by its two-bit tag.
// Idle and illegal words are discarded. Accepted words are counted per
// class and buffered in a DEPTH-entry circular FIFO. The FIFO drains to
// the host through a valid/ready handshake.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous active-low reset (no clock needed)
//   __in0       word from the upstream __out0 stream
//   in_valid    __in0 carries a word this cycle (never back-pressured)
//   clear       synchronous clear of counters and sticky flags (FIFO kept)
//   out_word    head-of-FIFO word, zero while the FIFO is empty
//   out_kind    class of the head word: 0 PLAIN, 1 TAGGED, 3 PAIR
//   out_valid   FIFO not empty
//   out_ready   host accepts the head word when out_valid is also high
//   cnt_plain   accepted PLAIN words   (saturating)
//   cnt_tagged  accepted TAGGED words  (saturating)
//   cnt_pair    accepted PAIR words    (saturating)
//   drop_count  candidates lost because the FIFO was full (saturating)
//   level       current FIFO occupancy, 0..DEPTH
//   overflow    sticky, set by any drop
//   illegal     sticky, set by any word carrying tag 2'b10
// ---------------------------------------------------------------------------
module rewire_out_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              __in0,
  input  logic                     in_valid,
  input  logic                     clear,
  output logic [15:0]              out_word,
  output logic [1:0]               out_kind,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            cnt_plain,
  output logic [CW-1:0]            cnt_tagged,
  output logic [CW-1:0]            cnt_pair,
  output logic [CW-1:0]            drop_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] TAG_PLAIN   = 2'b00;
  localparam logic [1:0] TAG_TAGGED  = 2'b01;
  localparam logic [1:0] TAG_ILLEGAL = 2'b10;
  localparam logic [1:0] TAG_PAIR    = 2'b11;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  // Class counter slots, used by the generate loop below.
  localparam int N_CLASS  = 3;
  localparam int IDX_PLAIN  = 0;
  localparam int IDX_TAGGED = 1;
  localparam int IDX_PAIR   = 2;

  // ------------------------------------------------------------------------
  // Classification of the incoming word
  // ------------------------------------------------------------------------
  logic [1:0]         in_tag;
  logic               in_is_idle;
  logic               in_is_illegal;
  logic               in_candidate;
  logic [N_CLASS-1:0] in_class_hit;

  assign in_tag        = __in0[15:14];
  // A PLAIN word with an all-zero payload is a bubble from the pipeline.
  assign in_is_idle    = (in_tag == TAG_PLAIN) && (__in0[8:0] == 9'h000);
  assign in_is_illegal = in_valid && (in_tag == TAG_ILLEGAL);
  assign in_candidate  = in_valid && (in_tag != TAG_ILLEGAL) && !in_is_idle;

  assign in_class_hit[IDX_PLAIN]  = (in_tag == TAG_PLAIN);
  assign in_class_hit[IDX_TAGGED] = (in_tag == TAG_TAGGED);
  assign in_class_hit[IDX_PAIR]   = (in_tag == TAG_PAIR);

  // ------------------------------------------------------------------------
  // FIFO control
  // ------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;

  logic fifo_empty;
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LEVEL_FULL);

  // The pop is decided from registered state and out_ready only, so a full
  // FIFO can still accept a word in the cycle its head leaves.
  assign do_pop  = !fifo_empty && out_ready;
  assign do_push = in_candidate && (!fifo_full || do_pop);
  assign do_drop = in_candidate && !do_push;

  always_comb begin
    level_next = level_reg;
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Pointers are AW bits wide, so the natural wrap of the adder gives the
  // modulo-DEPTH behaviour for any power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
    end
  end

  // ------------------------------------------------------------------------
  // Storage: 18 bits per entry, {kind, word}. The array is not reset; the
  // pointers and level define which entries are meaningful.
  // ------------------------------------------------------------------------
  logic [17:0] mem [DEPTH];
  logic [17:0] head_entry;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= {in_tag, __in0};
    end
  end

  // The head is read straight from the array at the registered read
  // pointer. It is forced to zero while empty so that reset (which empties
  // the FIFO asynchronously) also zeroes out_word and out_kind.
  assign head_entry = fifo_empty ? 18'h0_0000 : mem[rd_ptr_reg];

  assign out_kind  = head_entry[17:16];
  assign out_word  = head_entry[15:0];
  assign out_valid = !fifo_empty;
  assign level     = level_reg;

  // ------------------------------------------------------------------------
  // Per-class counters. A class counter only moves when its word was
  // really pushed. clear takes priority over any event in the same cycle.
  // ------------------------------------------------------------------------
  logic [CW-1:0] cnt_reg [N_CLASS];

  for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_class_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg[gi] <= '0;
      end else if (clear) begin
        cnt_reg[gi] <= '0;
      end else if (do_push && in_class_hit[gi] && (cnt_reg[gi] != CNT_MAX)) begin
        cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
      end
    end
  end

  assign cnt_plain  = cnt_reg[IDX_PLAIN];
  assign cnt_tagged = cnt_reg[IDX_TAGGED];
  assign cnt_pair   = cnt_reg[IDX_PAIR];

  // ------------------------------------------------------------------------
  // Drop counter and sticky status
  // ------------------------------------------------------------------------
  logic [CW-1:0] drop_count_reg;
  logic          overflow_reg;
  logic          illegal_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
      illegal_reg    <= 1'b0;
    end else if (clear) begin
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      if (do_drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != CNT_MAX) begin
          drop_count_reg <= drop_count_reg + CW'(1);
        end
      end
      if (in_is_illegal) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  assign drop_count = drop_count_reg;
  assign overflow   = overflow_reg;
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_rewire_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_rewire_out_fifo
//
// Drives rewire_out_fifo (DEPTH=8, CW=8) through directed vectors, a few
// multi-cycle corner sequences and a randomized run. A queue-based model of
// the block is updated once per clock and compared against every output.
// ---------------------------------------------------------------------------
module tb_rewire_out_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXC  = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic [15:0]     in_word;
  logic            in_valid;
  logic            clear;
  logic [15:0]     out_word;
  logic [1:0]      out_kind;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   cnt_plain;
  logic [CW-1:0]   cnt_tagged;
  logic [CW-1:0]   cnt_pair;
  logic [CW-1:0]   drop_count;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            illegal;

  rewire_out_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .__in0      (in_word),
    .in_valid   (in_valid),
    .clear      (clear),
    .out_word   (out_word),
    .out_kind   (out_kind),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cnt_plain  (cnt_plain),
    .cnt_tagged (cnt_tagged),
    .cnt_pair   (cnt_pair),
    .drop_count (drop_count),
    .level      (level),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: a plain queue of accepted entries plus counters.
  // ------------------------------------------------------------------------
  typedef struct {
    logic [15:0] w;
    logic [1:0]  k;
  } ent_t;

  ent_t m_q[$];
  int   m_plain, m_tagged, m_pair, m_drop;
  bit   m_ovf, m_ill;

  function automatic int sat_inc(int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_plain = 0; m_tagged = 0; m_pair = 0; m_drop = 0;
    m_ovf = 0; m_ill = 0;
  endtask

  task automatic model_step(bit iv, logic [15:0] w, bit clr, bit rdy);
    bit   pop;
    bit   cand;
    bit   push;
    logic [1:0] tag;
    ent_t e;
    tag  = w[15:14];
    pop  = (m_q.size() > 0) && rdy;
    cand = iv && (tag != 2'b10) && !((tag == 2'b00) && (w[8:0] == 9'h000));
    push = cand && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.w = w;
      e.k = tag;
      m_q.push_back(e);
    end
    if (clr) begin
      m_plain = 0; m_tagged = 0; m_pair = 0; m_drop = 0;
      m_ovf = 0; m_ill = 0;
    end else begin
      if (push) begin
        case (tag)
          2'b00:   m_plain  = sat_inc(m_plain);
          2'b01:   m_tagged = sat_inc(m_tagged);
          default: m_pair   = sat_inc(m_pair);
        endcase
      end
      if (cand && !push) begin
        m_drop = sat_inc(m_drop);
        m_ovf  = 1;
      end
      if (iv && tag == 2'b10) m_ill = 1;
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".out_valid"},  out_valid,  m_q.size() != 0);
    check({tag, ".out_word"},   out_word,   (m_q.size() != 0) ? m_q[0].w : 16'h0);
    check({tag, ".out_kind"},   out_kind,   (m_q.size() != 0) ? m_q[0].k : 2'd0);
    check({tag, ".level"},      level,      m_q.size());
    check({tag, ".cnt_plain"},  cnt_plain,  m_plain);
    check({tag, ".cnt_tagged"}, cnt_tagged, m_tagged);
    check({tag, ".cnt_pair"},   cnt_pair,   m_pair);
    check({tag, ".drop_count"}, drop_count, m_drop);
    check({tag, ".overflow"},   overflow,   m_ovf);
    check({tag, ".illegal"},    illegal,    m_ill);
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after.
  task automatic cyc(string tag, bit iv, logic [15:0] w, bit clr, bit rdy);
    in_valid  = iv;
    in_word   = w;
    clear     = clr;
    out_ready = rdy;
    @(posedge clk);
    model_step(iv, w, clr, rdy);
    #1;
    check_all(tag);
  endtask

  // ------------------------------------------------------------------------
  // Directed vectors with hand-derived expectations
  // ------------------------------------------------------------------------
  typedef struct {
    bit          iv;
    logic [15:0] w;
    bit          clr;
    bit          rdy;
    bit          e_valid;
    logic [15:0] e_word;
    logic [1:0]  e_kind;
    int          e_level;
    bit          e_ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 16'hC00F, 1'b0, 1'b1, 1'b1, 16'hC00F, 2'd3, 1, 1'b0};
    vecs[1] = '{1'b1, 16'h41AA, 1'b0, 1'b1, 1'b1, 16'h41AA, 2'd1, 1, 1'b0};
    vecs[2] = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0005, 2'd0, 1, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 0, 1'b0};
    vecs[4] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 0, 1'b0};
    vecs[5] = '{1'b1, 16'h8123, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 0, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 0, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_word = 16'h0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); @(posedge clk);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // ---- directed table ----
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].iv, vecs[i].w, vecs[i].clr, vecs[i].rdy);
      check($sformatf("vec%0d.valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d.word", i),  out_word,  vecs[i].e_word);
      check($sformatf("vec%0d.kind", i),  out_kind,  vecs[i].e_kind);
      check($sformatf("vec%0d.level", i), level,     vecs[i].e_level);
      check($sformatf("vec%0d.illegal", i), illegal, vecs[i].e_ill);
      if (i == 2) begin
        check("vec2.cnt_pair",   cnt_pair,   1);
        check("vec2.cnt_tagged", cnt_tagged, 1);
        check("vec2.cnt_plain",  cnt_plain,  1);
      end
    end
    $display("directed vectors done, %0d checks so far", n_checks);

    // ---- overfill with out_ready=0 ----
    for (int i = 1; i <= 10; i++) cyc("fill", 1'b1, 16'(i), 1'b0, 1'b0);
    check("fill.level", level, 8);
    check("fill.drop_count", drop_count, 2);
    check("fill.overflow", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      check("drain.word", out_word, k);
      cyc("drain", 1'b0, 16'h0, 1'b0, 1'b1);
    end
    check("drain.empty", out_valid, 0);
    $display("overfill/drain done, %0d checks so far", n_checks);

    // ---- full FIFO with simultaneous push and pop, across pointer wrap ----
    for (int i = 0; i < 8; i++) cyc("refill", 1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc("stream", 1'b1, 16'h0018 + 16'(i), 1'b0, 1'b1);
      check("stream.level", level, 8);
      check("stream.drop_count", drop_count, 2);
      check("stream.head", out_word, 16'h0011 + 16'(i));
    end
    for (int i = 0; i < 8; i++) begin
      check("stream_drain.word", out_word, 16'h0024 + 16'(i));
      cyc("stream_drain", 1'b0, 16'h0, 1'b0, 1'b1);
    end
    $display("full streaming done, %0d checks so far", n_checks);

    // ---- counter saturation ----
    cyc("sat_clear", 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 1; i <= 260; i++) cyc("sat", 1'b1, 16'(i), 1'b0, 1'b1);
    check("sat.cnt_plain", cnt_plain, 255);
    check("sat.level", level, 1);
    cyc("sat_drain", 1'b0, 16'h0, 1'b0, 1'b1);
    $display("saturation done, %0d checks so far", n_checks);

    // ---- randomized run against the model ----
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  t;
      logic [15:0] w;
      bit          iv, clr, rdy;
      case ($urandom_range(0, 9))
        0, 1, 2: t = 2'b00;
        3, 4:    t = 2'b01;
        5, 6, 7: t = 2'b11;
        default: t = 2'b10;
      endcase
      w = {t, 14'($urandom)};
      if ($urandom_range(0, 7) == 0) w = 16'h0000;
      iv  = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 29) == 0);
      rdy = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      cyc("rand", iv, w, clr, rdy);
    end
    $display("random run done, %0d checks so far", n_checks);

    // ---- asynchronous reset with level=5 ----
    cyc("pre_rst_clear", 1'b0, 16'h0, 1'b1, 1'b1);
    cyc("pre_rst_clear", 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 16'h4100 + 16'(i), 1'b0, 1'b0);
    cyc("pre_rst_ill", 1'b1, 16'h8001, 1'b0, 1'b0);
    check("pre_rst.level", level, 5);
    in_valid = 1'b1; in_word = 16'hC123; out_ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("rst_async.out_valid", out_valid, 0);
    check("rst_async.level", level, 0);
    check("rst_async.illegal", illegal, 0);
    check_all("rst_async");
    @(posedge clk);
    #4 rst = 1'b1;
    cyc("post_rst", 1'b1, 16'h4055, 1'b0, 1'b0);
    check("post_rst.head", out_word, 16'h4055);
    check("post_rst.level", level, 1);
    cyc("post_rst_drain", 1'b0, 16'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound in case something stalls the stimulus.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
